uart_program_loader: RTL



---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/uart_rx_core.sv | 92 +++++++++
 rtl/uart_program_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the UART program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        FLUSH,
        DONE
    } loader_state_t;

    localparam int WORD_BYTES     = 4;
    localparam int RX_SYNC_STAGES = 2;

    function automatic int cpb_calc(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver with start-bit glitch rejection
module uart_rx_core
    import prog_loader_pkg::*;
#(
    parameter int CPB = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int CW   = $clog2(CPB + 1);
    localparam int HALF = CPB / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t                 state;
    logic [RX_SYNC_STAGES-1:0] sync;
    logic                      rx_s;
    logic                      rx_prev;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [7:0]                shreg;

    assign rx_s = sync[RX_SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync         <= '1;
            rx_prev      <= 1'b1;
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            byte_valid_o <= 1'b0;
            byte_o       <= '0;
            frame_err_o  <= 1'b0;
        end else begin
            sync         <= {sync[RX_SYNC_STAGES-2:0], rx_i};
            rx_prev      <= rx_s;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // a line that is high again at mid start bit was only a glitch
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            byte_valid_o <= 1'b1;
                            byte_o       <= shreg;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART download into instruction memory; PROG_LOADER_CHECKSUM_EN adds checksum_o
module uart_program_loader
    import prog_loader_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          BAUD_RATE   = 9600,
    parameter int          CPB         = cpb_calc(CLK_FREQ_HZ, BAUD_RATE),
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_BYTES   = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        programmer_mode_i,
    input  logic        rx_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic [31:0] byte_count_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        addr_err_o
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum_o
`endif
);

    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    loader_state_t state;
    logic [31:0]   addr;
    logic [1:0]    idx;
    logic [31:0]   word_buf;
    logic [7:0]    buf_byte;
    logic          buf_full;
    logic          end_pend;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_ferr;
    logic          consume;
    logic          accept;
    logic          addr_ok;

    uart_rx_core #(.CPB(CPB)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_ferr)
    );

    assign consume = (state == COLLECT) && buf_full;
    assign accept  = (state == COLLECT) || (state == WRITE);
    assign addr_ok = {1'b0, addr} < ADDR_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= BASE_ADDR;
            idx          <= '0;
            word_buf     <= '0;
            buf_byte     <= '0;
            buf_full     <= 1'b0;
            end_pend     <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_be_o     <= '0;
            cpu_hold_o   <= 1'b0;
            done_o       <= 1'b0;
            byte_count_o <= '0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            addr_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (programmer_mode_i) begin
                        idx          <= '0;
                        word_buf     <= '0;
                        buf_full     <= 1'b0;
                        end_pend     <= 1'b0;
                        byte_count_o <= '0;
                        frame_err_o  <= 1'b0;
                        overrun_o    <= 1'b0;
                        addr_err_o   <= 1'b0;
                        addr         <= BASE_ADDR;
                        cpu_hold_o   <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (consume) begin
                        byte_count_o <= byte_count_o + 32'd1;
                        idx          <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            mem_wdata_o <= {buf_byte, word_buf[23:0]};
                            mem_be_o    <= 4'hF;
                            mem_addr_o  <= addr;
                            mem_req_o   <= addr_ok;
                            if (!addr_ok) addr_err_o <= 1'b1;
                            word_buf    <= '0;
                            end_pend    <= end_pend || !programmer_mode_i;
                            state       <= WRITE;
                        end else begin
                            word_buf[{idx, 3'b000} +: 8] <= buf_byte;
                        end
                    end else if (!programmer_mode_i || end_pend) begin
                        end_pend <= 1'b0;
                        if (idx != 2'd0) begin
                            mem_wdata_o <= word_buf;
                            mem_be_o    <= (4'd1 << idx) - 4'd1;
                            mem_addr_o  <= addr;
                            mem_req_o   <= addr_ok;
                            if (!addr_ok) addr_err_o <= 1'b1;
                            word_buf    <= '0;
                            idx         <= '0;
                            state       <= FLUSH;
                        end else begin
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                WRITE, FLUSH: begin
                    if (state == WRITE && !programmer_mode_i) end_pend <= 1'b1;
                    // a suppressed out-of-range write never raised mem_req_o and completes at once
                    if (!mem_req_o || mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        addr      <= addr + 32'(WORD_BYTES);
                        if (state == FLUSH ||
                            ((end_pend || !programmer_mode_i) && !buf_full)) begin
                            end_pend   <= 1'b0;
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                            state      <= DONE;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    done_o   <= 1'b0;
                    buf_full <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // holding buffer; a byte consumed this cycle frees the slot for a new arrival
            if (rx_valid && accept) begin
                if (buf_full && !consume) begin
                    overrun_o <= 1'b1;
                end else begin
                    buf_byte <= rx_byte;
                    buf_full <= 1'b1;
                end
            end else if (consume) begin
                buf_full <= 1'b0;
            end
            if (rx_ferr && accept) frame_err_o <= 1'b1;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_o <= '0;
        end else if (state == IDLE && programmer_mode_i) begin
            checksum_o <= '0;
        end else if ((state == WRITE || state == FLUSH) && mem_req_o && mem_gnt_i) begin
            checksum_o <= checksum_o + mem_wdata_o;
        end
    end
`endif

endmodule
